// File: rtl/tag_compare_nway_pkg.sv
// Shared types and width/field helpers for the N-way tag comparator.
// Beat layout, MSB first: {dirty, valid, tag[TAG_W], data[LINE_W]}.
package tag_compare_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_RESP
  } state_e;

  function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int calc_beat_w(input int line_w, input int tag_w);
    return line_w + tag_w + 2;
  endfunction

  function automatic int beat_tag_lsb(input int line_w);
    return line_w;
  endfunction

  function automatic int beat_valid_bit(input int line_w, input int tag_w);
    return line_w + tag_w;
  endfunction

  function automatic int beat_dirty_bit(input int line_w, input int tag_w);
    return line_w + tag_w + 1;
  endfunction

endpackage

// File: rtl/tag_compare_nway_if.sv
// Request, R-channel and result bundle of the tag comparator.
// slave = comparator side, master = request/memory/consumer side.
interface tag_compare_nway_if
  import tag_compare_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 20,
  parameter int WAYS     = 4,
  parameter int LINE_W   = 512,
  parameter int ID_W     = 4
);
  localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int WAY_W  = calc_way_w(WAYS);
  localparam int BEAT_W = calc_beat_w(LINE_W, TAG_W);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [ID_W-1:0]   req_id_i;

  logic [ID_W-1:0]   rid_i;
  logic [BEAT_W-1:0] rdata_i;
  logic              rlast_i;
  logic              rvalid_i;
  logic              rready_o;

  logic              res_valid_o;
  logic              res_ready_i;
  logic [ID_W-1:0]   res_id_o;
  logic              res_write_o;
  logic              res_hit_o;
  logic [WAY_W-1:0]  res_way_o;
  logic [LINE_W-1:0] res_data_o;
  logic              res_victim_dirty_o;
  logic [TAG_W-1:0]  res_victim_tag_o;
  logic              res_error_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_id_i,
    input  rid_i, rdata_i, rlast_i, rvalid_i,
    input  res_ready_i,
    output req_ready_o, rready_o,
    output res_valid_o, res_id_o, res_write_o, res_hit_o, res_way_o,
    output res_data_o, res_victim_dirty_o, res_victim_tag_o, res_error_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_id_i,
    output rid_i, rdata_i, rlast_i, rvalid_i,
    output res_ready_i,
    input  req_ready_o, rready_o,
    input  res_valid_o, res_id_o, res_write_o, res_hit_o, res_way_o,
    input  res_data_o, res_victim_dirty_o, res_victim_tag_o, res_error_o
  );

endinterface

// File: rtl/tag_compare_nway_victim_select.sv
// Victim choice: first invalid way, else the round-robin way; combinational.
// Holds the round-robin pointer, advanced by the parent on all-valid miss handshakes.
module victim_select
  import tag_compare_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int TAG_W = 38,
  parameter int WAY_W = calc_way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WAYS-1:0]  i_meta_vld,
  input  logic [WAYS-1:0]  i_meta_dty,
  input  logic [TAG_W-1:0] i_meta_tag [WAYS],
  input  logic             i_rr_adv,
  output logic [WAY_W-1:0] o_way,
  output logic             o_dirty,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_all_vld
);

  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] r_rr;
  logic [WAY_W-1:0] w_first_inv;
  logic             w_found_inv;
  logic [WAY_W-1:0] w_way;

  always_comb begin
    w_found_inv = 1'b0;
    w_first_inv = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!i_meta_vld[i] && !w_found_inv) begin
        w_found_inv = 1'b1;
        w_first_inv = WAY_W'(i);
      end
    end
  end

  assign w_way     = w_found_inv ? w_first_inv : r_rr;
  assign o_way     = w_way;
  assign o_all_vld = &i_meta_vld;
  // An invalid victim carries no writeback and reports a zero tag.
  assign o_dirty   = i_meta_vld[w_way] && i_meta_dty[w_way];
  assign o_tag     = i_meta_vld[w_way] ? i_meta_tag[w_way] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (i_rr_adv) begin
      r_rr <= (r_rr == LAST_WAY) ? '0 : r_rr + WAY_W'(1);
    end
  end

endmodule

// File: rtl/tag_compare_nway.sv
// N-way tag compare on the DRAM cache read path: one request plus WAYS R beats -> one result.
// Result valid the cycle after the last beat; held stable, and no new request/beat taken, until res_ready_i.
module tag_compare_nway
  import tag_compare_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 20,
  parameter int WAYS     = 4,
  parameter int LINE_W   = 512,
  parameter int ID_W     = 4
) (
  input logic              clk,
  input logic              rst_n,
  tag_compare_nway_if.slave bus
);

  localparam int TAG_W   = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int WAY_W   = calc_way_w(WAYS);
  localparam int TAG_LSB = beat_tag_lsb(LINE_W);
  localparam int VLD_BIT = beat_valid_bit(LINE_W, TAG_W);
  localparam int DTY_BIT = beat_dirty_bit(LINE_W, TAG_W);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  state_e           r_state;
  logic             r_req_rdy;
  logic             r_rready;
  logic             r_res_vld;
  logic             r_res_write;
  logic             r_res_hit;
  logic             r_res_vdirty;
  logic             r_res_err;
  logic [ID_W-1:0]  r_res_id;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_res_vtag;
  logic [WAY_W-1:0] r_cnt;
  logic [WAY_W-1:0] r_res_way;
  logic [LINE_W-1:0] r_res_data;
  logic [WAYS-1:0]  r_meta_vld;
  logic [WAYS-1:0]  r_meta_dty;
  logic [TAG_W-1:0] r_meta_tag [WAYS];
  logic             r_all_vld;

  logic             w_beat_acc;
  logic             w_beat_vld;
  logic             w_beat_dty;
  logic [TAG_W-1:0] w_beat_tag;
  logic [LINE_W-1:0] w_beat_data;
  logic             w_match;
  logic             w_last_way;
  logic             w_exit;
  logic             w_beat_err;
  logic             w_hit_next;
  logic             w_rr_adv;
  logic [WAYS-1:0]  w_meta_vld;
  logic [WAYS-1:0]  w_meta_dty;
  logic [TAG_W-1:0] w_meta_tag [WAYS];
  logic [WAY_W-1:0] w_vic_way;
  logic             w_vic_dty;
  logic [TAG_W-1:0] w_vic_tag;
  logic             w_all_vld;
  logic             w_unused_addr;

  assign w_unused_addr = ^bus.req_addr_i[ADDR_W-TAG_W-1:0];

  assign w_beat_acc  = (r_state == S_COLLECT) && bus.rvalid_i;
  assign w_beat_vld  = bus.rdata_i[VLD_BIT];
  assign w_beat_dty  = bus.rdata_i[DTY_BIT];
  assign w_beat_tag  = bus.rdata_i[TAG_LSB +: TAG_W];
  assign w_beat_data = bus.rdata_i[LINE_W-1:0];
  assign w_match     = w_beat_vld && (w_beat_tag == r_tag);
  assign w_last_way  = (r_cnt == LAST_WAY);
  assign w_exit      = w_beat_acc && (w_last_way || bus.rlast_i);
  assign w_hit_next  = r_res_hit || w_match;
  // rlast must coincide exactly with the last way; either mismatch is a protocol error.
  assign w_beat_err  = (bus.rid_i != r_res_id) || (w_match && r_res_hit) ||
                       (bus.rlast_i != w_last_way);
  assign w_rr_adv    = r_res_vld && bus.res_ready_i && !r_res_hit && r_all_vld;

  // Metadata including the beat in flight, so the victim is known on the exit edge.
  always_comb begin
    w_meta_vld = r_meta_vld;
    w_meta_dty = r_meta_dty;
    w_meta_tag = r_meta_tag;
    if (w_beat_acc) begin
      w_meta_vld[r_cnt] = w_beat_vld;
      w_meta_dty[r_cnt] = w_beat_dty;
      w_meta_tag[r_cnt] = w_beat_tag;
    end
  end

  victim_select #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_vsel (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_meta_vld (w_meta_vld),
    .i_meta_dty (w_meta_dty),
    .i_meta_tag (w_meta_tag),
    .i_rr_adv   (w_rr_adv),
    .o_way      (w_vic_way),
    .o_dirty    (w_vic_dty),
    .o_tag      (w_vic_tag),
    .o_all_vld  (w_all_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_rdy    <= 1'b1;
      r_rready     <= 1'b0;
      r_res_vld    <= 1'b0;
      r_res_write  <= 1'b0;
      r_res_hit    <= 1'b0;
      r_res_vdirty <= 1'b0;
      r_res_err    <= 1'b0;
      r_res_id     <= '0;
      r_tag        <= '0;
      r_res_vtag   <= '0;
      r_cnt        <= '0;
      r_res_way    <= '0;
      r_res_data   <= '0;
      r_meta_vld   <= '0;
      r_meta_dty   <= '0;
      r_all_vld    <= 1'b0;
      for (int i = 0; i < WAYS; i++) r_meta_tag[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_state      <= S_COLLECT;
            r_req_rdy    <= 1'b0;
            r_rready     <= 1'b1;
            r_res_write  <= bus.req_write_i;
            r_tag        <= bus.req_addr_i[ADDR_W-1 -: TAG_W];
            r_res_id     <= bus.req_id_i;
            r_cnt        <= '0;
            r_res_hit    <= 1'b0;
            r_res_err    <= 1'b0;
            r_res_way    <= '0;
            r_res_data   <= '0;
            r_res_vdirty <= 1'b0;
            r_res_vtag   <= '0;
            r_meta_vld   <= '0;
          end
        end
        S_COLLECT: begin
          if (w_beat_acc) begin
            r_cnt      <= r_cnt + WAY_W'(1);
            r_meta_vld <= w_meta_vld;
            r_meta_dty <= w_meta_dty;
            r_meta_tag <= w_meta_tag;
            if (w_beat_err) r_res_err <= 1'b1;
            if (w_match && !r_res_hit) begin
              r_res_hit  <= 1'b1;
              r_res_way  <= r_cnt;
              r_res_data <= w_beat_data;
            end
            if (w_exit) begin
              r_state   <= S_RESP;
              r_rready  <= 1'b0;
              r_res_vld <= 1'b1;
              r_all_vld <= w_all_vld;
              if (!w_hit_next) begin
                r_res_way    <= w_vic_way;
                r_res_vdirty <= w_vic_dty;
                r_res_vtag   <= w_vic_tag;
              end
            end
          end
        end
        S_RESP: begin
          if (bus.res_ready_i) begin
            r_state   <= S_IDLE;
            r_res_vld <= 1'b0;
            r_req_rdy <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o        = r_req_rdy;
  assign bus.rready_o           = r_rready;
  assign bus.res_valid_o        = r_res_vld;
  assign bus.res_id_o           = r_res_id;
  assign bus.res_write_o        = r_res_write;
  assign bus.res_hit_o          = r_res_hit;
  assign bus.res_way_o          = r_res_way;
  assign bus.res_data_o         = r_res_data;
  assign bus.res_victim_dirty_o = r_res_vdirty;
  assign bus.res_victim_tag_o   = r_res_vtag;
  assign bus.res_error_o        = r_res_err;

endmodule

// File: tb/tb_tag_compare_nway.sv
// Directed bench for tag_compare_nway with WAYS=4; expected values are hand-derived per scenario.
module tb_tag_compare_nway;
  import tag_compare_pkg::*;

  localparam int ADDR_W = 64, OFFSET_W = 6, INDEX_W = 20, WAYS = 4, LINE_W = 512, ID_W = 4;
  localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int WAY_W  = calc_way_w(WAYS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tag_compare_nway_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
                        .WAYS(WAYS), .LINE_W(LINE_W), .ID_W(ID_W)) bus ();

  tag_compare_nway #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
                     .WAYS(WAYS), .LINE_W(LINE_W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [TAG_W-1:0] b_tag [4];
  logic             b_vld [4];
  logic             b_dty [4];
  logic [ID_W-1:0]  b_rid [4];

  function automatic logic [LINE_W-1:0] mkdata(input int k);
    logic [31:0] w;
    w = 32'hD00D_0000 | 32'(k);
    return {(LINE_W/32){w}};
  endfunction

  task automatic drive_idle();
    bus.req_valid_i = 0; bus.req_write_i = 0; bus.req_addr_i = '0; bus.req_id_i = '0;
    bus.rid_i = '0; bus.rdata_i = '0; bus.rlast_i = 0; bus.rvalid_i = 0; bus.res_ready_i = 0;
  endtask

  task automatic set_ways(input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                          input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] t3,
                          input logic [3:0] v, input logic [3:0] d, input logic [ID_W-1:0] id);
    b_tag[0] = t0; b_tag[1] = t1; b_tag[2] = t2; b_tag[3] = t3;
    for (int i = 0; i < 4; i++) begin
      b_vld[i] = v[i]; b_dty[i] = d[i]; b_rid[i] = id;
    end
  endtask

  task automatic send_req(input logic w, input logic [TAG_W-1:0] t, input logic [ID_W-1:0] id);
    bus.req_valid_i = 1; bus.req_write_i = w; bus.req_addr_i = {t, 20'hABCDE, 6'h15}; bus.req_id_i = id;
    for (int n = 0; n < 20; n++) begin
      if (bus.req_ready_o === 1'b1) begin
        @(posedge clk); #1;
        bus.req_valid_i = 0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.req_valid_i = 0;
    checks++; errors++;
    $display("FAIL req_accept_timeout: req_ready=%b want 1", bus.req_ready_o);
  endtask

  task automatic send_beat(input int k, input logic last);
    bus.rvalid_i = 1; bus.rid_i = b_rid[k]; bus.rlast_i = last;
    bus.rdata_i = {b_dty[k], b_vld[k], b_tag[k], mkdata(k)};
    for (int n = 0; n < 20; n++) begin
      if (bus.rready_o === 1'b1) begin
        @(posedge clk); #1;
        bus.rvalid_i = 0; bus.rlast_i = 0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.rvalid_i = 0; bus.rlast_i = 0;
    checks++; errors++;
    $display("FAIL beat_accept_timeout: rready=%b want 1", bus.rready_o);
  endtask

  task automatic run_txn(input logic w, input logic [TAG_W-1:0] t, input logic [ID_W-1:0] id,
                         input int nbeats, input logic last_flag);
    send_req(w, t, id);
    for (int k = 0; k < nbeats; k++) send_beat(k, (k == nbeats - 1) ? last_flag : 1'b0);
  endtask

  task automatic take_result();
    bus.res_ready_i = 1;
    @(posedge clk); #1;
    bus.res_ready_i = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready_o); end
    checks++; if (bus.rready_o !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", bus.rready_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid_o); end
    checks++; if (bus.res_hit_o !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", bus.res_hit_o); end
    checks++; if (bus.res_error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.res_error_o); end
    checks++; if (bus.res_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.res_data_o); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_hit();
    set_ways(38'h3, 38'h12, 38'h7, 38'h9, 4'hF, 4'h0, 4'd3);
    run_txn(1'b0, 38'h12, 4'd3, 4, 1'b1);
    checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL hit_latency: res_valid=%b want 1", bus.res_valid_o); end
    checks++; if (bus.res_hit_o !== 1'b1) begin errors++; $display("FAIL hit_flag: got %b want 1", bus.res_hit_o); end
    checks++; if (bus.res_way_o !== 2'd1) begin errors++; $display("FAIL hit_way: got %0d want 1", bus.res_way_o); end
    checks++; if (bus.res_data_o !== mkdata(1)) begin errors++; $display("FAIL hit_data: got %h want %h", bus.res_data_o, mkdata(1)); end
    checks++; if (bus.res_error_o !== 1'b0) begin errors++; $display("FAIL hit_error: got %b want 0", bus.res_error_o); end
    checks++; if (bus.res_id_o !== 4'd3) begin errors++; $display("FAIL hit_id: got %0d want 3", bus.res_id_o); end
    checks++; if (bus.res_write_o !== 1'b0) begin errors++; $display("FAIL hit_write: got %b want 0", bus.res_write_o); end
    checks++; if (bus.rready_o !== 1'b0) begin errors++; $display("FAIL hit_rready: got %b want 0", bus.rready_o); end
    take_result();
    checks++; if (bus.res_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errors++;
      $display("FAIL hit_handshake: res_valid=%b req_ready=%b want 0/1", bus.res_valid_o, bus.req_ready_o); end
  endtask

  // rr walks 0->1->2->3->0 over four all-valid misses.
  task automatic test_rr_misses();
    set_ways(38'h1, 38'h2, 38'h3, 38'h4, 4'hF, 4'h0, 4'd5);
    run_txn(1'b0, 38'h55, 4'd5, 4, 1'b1);
    checks++; if (bus.res_hit_o !== 1'b0 || bus.res_way_o !== 2'd0) begin errors++;
      $display("FAIL rr0_way: hit=%b way=%0d want 0/0", bus.res_hit_o, bus.res_way_o); end
    checks++; if (bus.res_data_o !== '0) begin errors++; $display("FAIL miss_data: got %h want 0", bus.res_data_o); end
    take_result();
    run_txn(1'b0, 38'h55, 4'd5, 4, 1'b1);
    checks++; if (bus.res_way_o !== 2'd1) begin errors++; $display("FAIL rr1_way: got %0d want 1", bus.res_way_o); end
    take_result();
    set_ways(38'h1, 38'h2, 38'h2A, 38'h4, 4'hF, 4'b0100, 4'd6);
    run_txn(1'b1, 38'h55, 4'd6, 4, 1'b1);
    checks++; if (bus.res_way_o !== 2'd2) begin errors++; $display("FAIL rr2_way: got %0d want 2", bus.res_way_o); end
    checks++; if (bus.res_victim_dirty_o !== 1'b1) begin errors++; $display("FAIL rr2_vdirty: got %b want 1", bus.res_victim_dirty_o); end
    checks++; if (bus.res_victim_tag_o !== 38'h2A) begin errors++; $display("FAIL rr2_vtag: got %h want 2a", bus.res_victim_tag_o); end
    checks++; if (bus.res_write_o !== 1'b1 || bus.res_error_o !== 1'b0) begin errors++;
      $display("FAIL rr2_write_err: write=%b err=%b want 1/0", bus.res_write_o, bus.res_error_o); end
    take_result();
    set_ways(38'h1, 38'h2, 38'h3, 38'h33, 4'hF, 4'b1000, 4'd6);
    run_txn(1'b1, 38'h55, 4'd6, 4, 1'b1);
    checks++; if (bus.res_way_o !== 2'd3 || bus.res_victim_tag_o !== 38'h33) begin errors++;
      $display("FAIL rr3_way: way=%0d vtag=%h want 3/33", bus.res_way_o, bus.res_victim_tag_o); end
    take_result();
  endtask

  task automatic test_invalid_victim();
    set_ways(38'h1, 38'h77, 38'h3, 38'h4, 4'b1101, 4'b0010, 4'd7);
    run_txn(1'b0, 38'h55, 4'd7, 4, 1'b1);
    checks++; if (bus.res_hit_o !== 1'b0 || bus.res_way_o !== 2'd1) begin errors++;
      $display("FAIL inv_way: hit=%b way=%0d want 0/1", bus.res_hit_o, bus.res_way_o); end
    checks++; if (bus.res_victim_dirty_o !== 1'b0) begin errors++; $display("FAIL inv_vdirty: got %b want 0", bus.res_victim_dirty_o); end
    checks++; if (bus.res_victim_tag_o !== '0) begin errors++; $display("FAIL inv_vtag: got %h want 0", bus.res_victim_tag_o); end
    take_result();
    set_ways(38'h11, 38'h12, 38'h13, 38'h14, 4'hF, 4'b0001, 4'd7);
    run_txn(1'b0, 38'h55, 4'd7, 4, 1'b1);
    checks++; if (bus.res_way_o !== 2'd0 || bus.res_victim_dirty_o !== 1'b1 || bus.res_victim_tag_o !== 38'h11) begin errors++;
      $display("FAIL rr_wrap: way=%0d vdirty=%b vtag=%h want 0/1/11", bus.res_way_o, bus.res_victim_dirty_o, bus.res_victim_tag_o); end
    take_result();
  endtask

  task automatic test_errors();
    set_ways(38'h12, 38'h5, 38'h6, 38'h12, 4'hF, 4'h0, 4'd9);
    run_txn(1'b0, 38'h12, 4'd9, 4, 1'b1);
    checks++; if (bus.res_hit_o !== 1'b1 || bus.res_way_o !== 2'd0 || bus.res_error_o !== 1'b1) begin errors++;
      $display("FAIL double_hit: hit=%b way=%0d err=%b want 1/0/1", bus.res_hit_o, bus.res_way_o, bus.res_error_o); end
    checks++; if (bus.res_data_o !== mkdata(0)) begin errors++; $display("FAIL double_hit_data: got %h want %h", bus.res_data_o, mkdata(0)); end
    take_result();
    set_ways(38'h1, 38'h2, 38'h3, 38'h4, 4'hF, 4'h0, 4'd2);
    run_txn(1'b0, 38'h12, 4'd2, 2, 1'b1);
    checks++; if (bus.res_valid_o !== 1'b1) begin errors++; $display("FAIL early_rlast_valid: got %b want 1", bus.res_valid_o); end
    checks++; if (bus.res_error_o !== 1'b1 || bus.res_hit_o !== 1'b0) begin errors++;
      $display("FAIL early_rlast_err: err=%b hit=%b want 1/0", bus.res_error_o, bus.res_hit_o); end
    checks++; if (bus.res_way_o !== 2'd2 || bus.res_victim_tag_o !== '0) begin errors++;
      $display("FAIL early_rlast_victim: way=%0d vtag=%h want 2/0", bus.res_way_o, bus.res_victim_tag_o); end
    take_result();
    set_ways(38'h1, 38'h12, 38'h3, 38'h4, 4'hF, 4'h0, 4'd1);
    run_txn(1'b0, 38'h12, 4'd1, 4, 1'b0);
    checks++; if (bus.res_valid_o !== 1'b1 || bus.res_error_o !== 1'b1 || bus.res_way_o !== 2'd1) begin errors++;
      $display("FAIL no_rlast: valid=%b err=%b way=%0d want 1/1/1", bus.res_valid_o, bus.res_error_o, bus.res_way_o); end
    take_result();
    set_ways(38'h1, 38'h2, 38'h3, 38'h12, 4'hF, 4'h0, 4'd4);
    b_rid[2] = 4'd5;
    run_txn(1'b0, 38'h12, 4'd4, 4, 1'b1);
    checks++; if (bus.res_hit_o !== 1'b1 || bus.res_way_o !== 2'd3 || bus.res_error_o !== 1'b1) begin errors++;
      $display("FAIL rid_err: hit=%b way=%0d err=%b want 1/3/1", bus.res_hit_o, bus.res_way_o, bus.res_error_o); end
    checks++; if (bus.res_id_o !== 4'd4) begin errors++; $display("FAIL rid_err_id: got %0d want 4", bus.res_id_o); end
    take_result();
  endtask

  task automatic test_stall();
    set_ways(38'h1, 38'h2, 38'h12, 38'h4, 4'hF, 4'h0, 4'd8);
    run_txn(1'b1, 38'h12, 4'd8, 4, 1'b1);
    bus.req_valid_i = 1; bus.rvalid_i = 1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.res_valid_o !== 1'b1 || bus.res_hit_o !== 1'b1 || bus.res_way_o !== 2'd2) begin errors++;
        $display("FAIL stall_hold c%0d: valid=%b hit=%b way=%0d want 1/1/2", c, bus.res_valid_o, bus.res_hit_o, bus.res_way_o); end
      checks++; if (bus.res_data_o !== mkdata(2)) begin errors++; $display("FAIL stall_data c%0d: got %h", c, bus.res_data_o); end
      checks++; if (bus.rready_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin errors++;
        $display("FAIL stall_ready c%0d: rready=%b req_ready=%b want 0/0", c, bus.rready_o, bus.req_ready_o); end
      @(posedge clk); #1;
    end
    bus.req_valid_i = 0; bus.rvalid_i = 0;
    take_result();
    checks++; if (bus.res_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin errors++;
      $display("FAIL stall_release: valid=%b req_ready=%b want 0/1", bus.res_valid_o, bus.req_ready_o); end
  endtask

  // rr is 1 here; after the reset an all-valid miss must pick way 0.
  task automatic test_reset_mid();
    set_ways(38'h1, 38'h2, 38'h3, 38'h4, 4'hF, 4'h0, 4'd3);
    send_req(1'b0, 38'h55, 4'd3);
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++; if (bus.req_ready_o !== 1'b1 || bus.rready_o !== 1'b0) begin errors++;
      $display("FAIL midrst_idle: req_ready=%b rready=%b want 1/0", bus.req_ready_o, bus.rready_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.res_valid_o); end
    run_txn(1'b0, 38'h55, 4'd3, 4, 1'b1);
    checks++; if (bus.res_way_o !== 2'd0 || bus.res_error_o !== 1'b0) begin errors++;
      $display("FAIL midrst_rr: way=%0d err=%b want 0/0", bus.res_way_o, bus.res_error_o); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_rr_misses();
    test_invalid_victim();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tag_compare_nway.md
Name: tag_compare_nway

Overview:
- Parametrised N-way tag comparator for the DRAM cache read path.
- Takes one request (read/write, address, ID) from the request FIFO and consumes the WAYS tag-and-data beats returned on the AXI R channel for that set.
- Resolves hit/miss, hit way, hit line data, and victim way plus dirty status for a miss.
- Hands one result per request to the reorder buffer and the fill/writeback logic through a valid/ready interface.

Parameters:
ADDR_W, 64, request address width
OFFSET_W, 6, line offset bits
INDEX_W, 20, set index bits
WAYS, 4, associativity (power of 2, ≥1)
LINE_W, 512, line data width
ID_W, 4, AXI ID width
(derived) TAG_W = ADDR_W-INDEX_W-OFFSET_W; WAY_W = max(1,$clog2(WAYS)); BEAT_W = LINE_W+TAG_W+2

Ports:
- Clock and reset:
  clk  in  1  clock
  rst_n  in  1  reset, synchronous, active-low
- Request in:
  req_valid_i  in  1  request valid
  req_ready_o  out  1  request accepted
  req_write_i  in  1  1=write, 0=read
  req_addr_i  in  ADDR_W  request address
  req_id_i  in  ID_W  expected R-channel ID
- R channel in:
  rid_i  in  ID_W  R ID
  rdata_i  in  BEAT_W  {dirty,valid,tag[TAG_W],data[LINE_W]}, MSB first
  rlast_i  in  1  last beat
  rvalid_i  in  1  beat valid
  rready_o  out  1  beat accepted
- Result out:
  res_valid_o  out  1  result valid
  res_ready_i  in  1  result consumed
  res_id_o  out  ID_W  request ID
  res_write_o  out  1  request type
  res_hit_o  out  1  tag hit
  res_way_o  out  WAY_W  hit way on hit, victim way on miss
  res_data_o  out  LINE_W  hit line data, 0 on miss
  res_victim_dirty_o  out  1  miss and victim valid&dirty (writeback needed)
  res_victim_tag_o  out  TAG_W  victim tag, 0 if victim invalid
  res_error_o  out  1  protocol/consistency error

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; every output 0 except req_ready_o; req_ready_o=1 once in IDLE; round-robin pointer rr=0. Reset mid-operation discards the latched request and partial results without emitting a result.
- Request tag = req_addr_i[ADDR_W-1 -: TAG_W]. Beat k (0-based count of accepted beats) describes way k.
- FSM:
  - IDLE: req_ready_o=1, rready_o=0. On req_valid_i: latch write/tag/id, clear beat counter, hit and error flags, go COLLECT.
  - COLLECT: rready_o=1, req_ready_o=0. Each accepted beat:
    - rid_i≠latched id: set error; the beat still counts as way k.
    - valid&&tag match with no prior hit: record hit way k, capture data.
    - valid&&tag match with a prior hit: set error; first hit is kept.
    - First invalid way seen: record it as victim candidate.
    - Capture tag/dirty of each way into a small per-way array.
    - Counter increments by 1.
    - Exit to RESP on the beat where k==WAYS-1 or rlast_i=1.
    - rlast_i=1 with k<WAYS-1: error; missing ways are treated as invalid.
    - rlast_i=0 at k==WAYS-1: error.
  - RESP: res_valid_o=1, outputs stable until res_ready_i; rready_o=0. On handshake go IDLE.
- Victim selection on miss: first invalid way if any, else way rr. rr increments mod WAYS on each miss handshake where all ways were valid; unchanged otherwise.
- Latency: last beat accepted at edge N → res_valid_o high from cycle N+1. Throughput: one request per WAYS+2 cycles minimum.
- WAYS=1: direct-mapped; single beat; rr stays 0.
- Outputs are registered. res_data_o is 0 on miss.

Decomposition:
- Package tag_compare_pkg:
  - state enum {S_IDLE,S_COLLECT,S_RESP}
  - beat field offset functions
  - derived TAG_W/WAY_W/BEAT_W helper functions
- Sub-module victim_select: way metadata vector + rr → victim way, victim dirty, victim tag. Combinational, plus rr register.

Test Plan:
- WAYS=4, read tag 0x12; beats way0..3 tags {0x3,0x12,0x7,0x9}, all valid; rlast on beat3 → res_hit=1, way=1, data=beat1 data, error=0, res_valid one cycle after beat3.
- Write miss, all valid, way2 dirty, rr=2 → hit=0, way=2, victim_dirty=1, victim_tag=way2 tag. rr becomes 3. Repeat with rr=3 and wrap → 0.
- Miss with way1 invalid, rr=0 → way=1, victim_dirty=0, victim_tag=0; rr unchanged.
- Two ways matching (way0 and way3) → way=0, error=1. rlast on beat1 only → error=1, result after beat1.
- res_ready_i held 0 for 5 cycles → outputs stable, rready_o=0, req_ready_o=0. rst_n=0 in COLLECT after 2 beats → next cycle IDLE, res_valid_o=0, rr=0.
